// File: rtl/ccs_adc2axi4lite_if.sv
// Bundle of the command/response port and the five AXI4-Lite channels of ccs_adc2axi4lite.
// The master modport is the manager's view; slave is the view of whoever drives commands and models the subordinate.
interface ccs_adc2axi4lite_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_wstrb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [2:0]            AWPROT;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [2:0]            ARPROT;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARPROT, ARVALID, RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARPROT, ARVALID, RREADY
    );
endinterface

// File: rtl/ccs_adc2axi4lite.sv
// Single-outstanding command/response to AXI4-Lite manager; all outputs registered except cmd_ready.
// Define ADC2AXI_ERRCNT_EN to add err_count, a saturating count of B/R responses with resp[1] set.
module ccs_adc2axi4lite #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    ccs_adc2axi4lite_if.master      bus
`ifdef ADC2AXI_ERRCNT_EN
    ,
    output logic [ERRCNT_WIDTH-1:0] err_count
`endif
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || ERRCNT_WIDTH < 1) begin : g_param_check
        $error("ccs_adc2axi4lite: DATA_WIDTH must be 32 or 64 and ERRCNT_WIDTH at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_RESP,
        S_RSP
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] awaddr_reg, awaddr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [STRB_WIDTH-1:0] wstrb_reg, wstrb_next;
    logic                  awvalid_reg, awvalid_next;
    logic                  wvalid_reg, wvalid_next;
    logic                  bready_reg, bready_next;
    logic [ADDR_WIDTH-1:0] araddr_reg, araddr_next;
    logic                  arvalid_reg, arvalid_next;
    logic                  rready_reg, rready_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic                  rsp_write_reg, rsp_write_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]            rsp_resp_reg, rsp_resp_next;

    always_comb begin
        state_next     = state_reg;
        awaddr_next    = awaddr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        bready_next    = bready_reg;
        araddr_next    = araddr_reg;
        arvalid_next   = arvalid_reg;
        rready_next    = rready_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_write_next = rsp_write_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_resp_next  = rsp_resp_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_write) begin
                        awaddr_next  = bus.cmd_addr;
                        wdata_next   = bus.cmd_wdata;
                        wstrb_next   = bus.cmd_wstrb;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = S_WR_REQ;
                    end else begin
                        araddr_next  = bus.cmd_addr;
                        arvalid_next = 1'b1;
                        state_next   = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                // AW and W complete independently; B is only accepted once both have gone.
                if (awvalid_reg && bus.AWREADY) awvalid_next = 1'b0;
                if (wvalid_reg && bus.WREADY)   wvalid_next  = 1'b0;
                if (!awvalid_next && !wvalid_next) begin
                    bready_next = 1'b1;
                    state_next  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bus.BVALID) begin
                    rsp_resp_next  = bus.BRESP;
                    rsp_rdata_next = '0;
                    rsp_write_next = 1'b1;
                    bready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = S_RSP;
                end
            end
            S_RD_REQ: begin
                if (bus.ARREADY) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (bus.RVALID) begin
                    rsp_rdata_next = bus.RDATA;
                    rsp_resp_next  = bus.RRESP;
                    rsp_write_next = 1'b0;
                    rready_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = S_RSP;
                end
            end
            S_RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_reg     <= S_IDLE;
            awaddr_reg    <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            araddr_reg    <= '0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_write_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= 2'b00;
        end else begin
            state_reg     <= state_next;
            awaddr_reg    <= awaddr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            bready_reg    <= bready_next;
            araddr_reg    <= araddr_next;
            arvalid_reg   <= arvalid_next;
            rready_reg    <= rready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_write_reg <= rsp_write_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_resp_reg  <= rsp_resp_next;
        end
    end

    // Gating with ARESETn keeps a command from being taken on a reset cycle.
    assign bus.cmd_ready = (state_reg == S_IDLE) & ARESETn;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_write = rsp_write_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_resp  = rsp_resp_reg;
    assign bus.AWADDR    = awaddr_reg;
    assign bus.AWPROT    = 3'b000;
    assign bus.AWVALID   = awvalid_reg;
    assign bus.WDATA     = wdata_reg;
    assign bus.WSTRB     = wstrb_reg;
    assign bus.WVALID    = wvalid_reg;
    assign bus.BREADY    = bready_reg;
    assign bus.ARADDR    = araddr_reg;
    assign bus.ARPROT    = 3'b000;
    assign bus.ARVALID   = arvalid_reg;
    assign bus.RREADY    = rready_reg;

`ifdef ADC2AXI_ERRCNT_EN
    logic [ERRCNT_WIDTH-1:0] err_count_reg;
    logic                    err_hs;

    assign err_hs = (bus.BVALID & bready_reg & bus.BRESP[1]) |
                    (bus.RVALID & rready_reg & bus.RRESP[1]);

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            err_count_reg <= '0;
        end else if (err_hs && (err_count_reg != {ERRCNT_WIDTH{1'b1}})) begin
            err_count_reg <= err_count_reg + ERRCNT_WIDTH'(1);
        end
    end

    assign err_count = err_count_reg;
`endif
endmodule

// File: tb/tb_ccs_adc2axi4lite.sv
// Randomised bench for ccs_adc2axi4lite: a cycle-stepped subordinate with a memory, checked against a command-level memory model.
module tb_ccs_adc2axi4lite;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int EW = 2;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    ccs_adc2axi4lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
`ifdef ADC2AXI_ERRCNT_EN
    logic [EW-1:0] err_count;
`endif

    ccs_adc2axi4lite #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERRCNT_WIDTH(EW)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
`ifdef ADC2AXI_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    typedef struct {
        bit            timeout;
        int            rsp_cycle;
        int            idle_cycle;
        logic          rsp_write;
        logic [DW-1:0] rsp_rdata;
        logic [1:0]    rsp_resp;
        logic [AW-1:0] axi_addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        int            aw_cycles;
        int            w_cycles;
        int            ar_cycles;
        bit            bready_bad;
        bit            axi_bad;
        bit            rsp_bad;
        bit            cmd_ready_busy;
    } obs_t;

    int n_cmp = 0;
    int n_bad = 0;
    int err_n = 0;
    int txn_no = 0;
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] sub_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] blank_word(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ DW'(a);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < SW; i++)
            if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [EW-1:0] exp_err();
        return EW'((err_n > ERR_MAX) ? ERR_MAX : err_n);
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : blank_word(a);
    endfunction

    task automatic clear_inputs();
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_wstrb = '0;
        bus.rsp_ready = 0; bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 2'b00;
        bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = '0; bus.RRESP = 2'b00;
    endtask

    // One command, with the subordinate inserting the given ready/response delays.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [SW-1:0] ws, input int aw_d, input int w_d, input int ar_d,
                           input int x_d, input logic [1:0] resp, input int rsp_d, output obs_t o);
        bit aw_done = 0, w_done = 0, ar_done = 0, x_done = 0, rsp_hs = 0, rsp_seen = 0, fin = 0;
        bit aw_hs, w_hs, ar_hs, x_hs;
        int aw_n = 0, w_n = 0, ar_n = 0, x_n = 0, rsp_n = 0, guard = 0;
        logic [DW-1:0] rd_word = '0;
        o = '{default: 0};
        @(negedge ACLK);
        while (!bus.cmd_ready && guard < 50) begin @(negedge ACLK); guard++; end
        bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wd; bus.cmd_wstrb = ws;
        for (int c = 1; c < 300 && !fin; c++) begin
            @(negedge ACLK);
            bus.cmd_valid = 0;
            if (rsp_hs) begin
                o.idle_cycle = bus.cmd_ready ? c : -1;
                bus.rsp_ready = 0;
                fin = 1;
            end else begin
                if (bus.cmd_ready) o.cmd_ready_busy = 1;
                if (bus.BREADY && (!wr || !(aw_done && w_done) || x_done)) o.bready_bad = 1;
                if (bus.RREADY && (wr || !ar_done || x_done)) o.axi_bad = 1;
                if ((bus.AWVALID || bus.WVALID) && !wr) o.axi_bad = 1;
                if (bus.ARVALID && wr) o.axi_bad = 1;
                aw_hs = 0; w_hs = 0; ar_hs = 0; x_hs = 0;
                if (wr && bus.AWVALID) begin
                    if (aw_done) o.axi_bad = 1;
                    if (aw_n == 0) o.axi_addr = bus.AWADDR;
                    else if (bus.AWADDR !== o.axi_addr) o.axi_bad = 1;
                    o.aw_cycles++;
                    aw_hs = (aw_n >= aw_d);
                    aw_n++;
                end
                bus.AWREADY = aw_hs;
                if (wr && bus.WVALID) begin
                    if (w_done) o.axi_bad = 1;
                    if (w_n == 0) begin o.wdata = bus.WDATA; o.wstrb = bus.WSTRB; end
                    else if (bus.WDATA !== o.wdata || bus.WSTRB !== o.wstrb) o.axi_bad = 1;
                    o.w_cycles++;
                    w_hs = (w_n >= w_d);
                    w_n++;
                end
                bus.WREADY = w_hs;
                if (!wr && bus.ARVALID) begin
                    if (ar_done) o.axi_bad = 1;
                    if (ar_n == 0) o.axi_addr = bus.ARADDR;
                    else if (bus.ARADDR !== o.axi_addr) o.axi_bad = 1;
                    o.ar_cycles++;
                    ar_hs = (ar_n >= ar_d);
                    ar_n++;
                    if (ar_hs) rd_word = sub_mem.exists(bus.ARADDR) ? sub_mem[bus.ARADDR] : blank_word(bus.ARADDR);
                end
                bus.ARREADY = ar_hs;
                bus.BVALID = 0; bus.RVALID = 0;
                if (wr && aw_done && w_done && !x_done) begin
                    x_n++;
                    bus.BVALID = (x_n > x_d); bus.BRESP = resp;
                    x_hs = bus.BVALID && bus.BREADY;
                    if (x_hs) begin
                        sub_mem[o.axi_addr] = merge(sub_mem.exists(o.axi_addr) ? sub_mem[o.axi_addr]
                                                    : blank_word(o.axi_addr), o.wdata, o.wstrb);
                    end
                end
                if (!wr && ar_done && !x_done) begin
                    x_n++;
                    bus.RVALID = (x_n > x_d); bus.RDATA = rd_word; bus.RRESP = resp;
                    x_hs = bus.RVALID && bus.RREADY;
                end
                bus.rsp_ready = 0;
                if (bus.rsp_valid) begin
                    if (!x_done) o.rsp_bad = 1;
                    if (!rsp_seen) begin
                        o.rsp_cycle = c; o.rsp_write = bus.rsp_write;
                        o.rsp_rdata = bus.rsp_rdata; o.rsp_resp = bus.rsp_resp;
                    end else if (bus.rsp_write !== o.rsp_write || bus.rsp_rdata !== o.rsp_rdata ||
                                 bus.rsp_resp !== o.rsp_resp) begin
                        o.rsp_bad = 1;
                    end
                    rsp_seen = 1;
                    if (rsp_n >= rsp_d) begin bus.rsp_ready = 1; rsp_hs = 1; end
                    rsp_n++;
                end
                aw_done |= aw_hs; w_done |= w_hs; ar_done |= ar_hs; x_done |= x_hs;
            end
        end
        clear_inputs();
        o.timeout = !fin;
        txn_no++;
        $display("txn %0d %s addr=%h wdata=%h strb=%h resp=%0d -> rsp_write=%0b rdata=%h rsp_resp=%0d rsp@%0d idle@%0d",
                 txn_no, wr ? "WR" : "RD", addr, wd, ws, resp, o.rsp_write, o.rsp_rdata, o.rsp_resp,
                 o.rsp_cycle, o.idle_cycle);
    endtask

    task automatic test_reset();
        ARESETn = 0;
        repeat (2) @(negedge ACLK);
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready got %b want 0", bus.cmd_ready); end
        n_cmp++;
        if ({bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY, bus.rsp_valid, bus.rsp_write} !== 7'b0) begin
            n_bad++; $display("FAIL reset_valids got %b want 0000000",
                {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY, bus.rsp_valid, bus.rsp_write});
        end
        n_cmp++;
        if ({bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB, bus.rsp_rdata, bus.rsp_resp, bus.AWPROT, bus.ARPROT} !== '0) begin
            n_bad++; $display("FAIL reset_data got aw=%h ar=%h wd=%h ws=%h rd=%h resp=%0d want all 0",
                bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB, bus.rsp_rdata, bus.rsp_resp);
        end
        ARESETn = 1;
        err_n = 0;
        @(negedge ACLK);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_cmd_ready got %b want 1", bus.cmd_ready); end
`ifdef ADC2AXI_ERRCNT_EN
        n_cmp++; if (err_count !== '0) begin n_bad++; $display("FAIL reset_err_count got %0d want 0", err_count); end
`endif
    endtask

    task automatic test_write_basic();
        obs_t o;
        ref_mem[12'h010] = merge(ref_read(12'h010), 32'hDEADBEEF, 4'hF);
        run_txn(1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 0, o);
        n_cmp++; if (o.timeout) begin n_bad++; $display("FAIL wr_basic_timeout got 1 want 0"); end
        n_cmp++; if (o.axi_addr !== 12'h010 || o.wdata !== 32'hDEADBEEF || o.wstrb !== 4'hF) begin
            n_bad++; $display("FAIL wr_basic_axi got %h/%h/%h want 010/deadbeef/f", o.axi_addr, o.wdata, o.wstrb); end
        n_cmp++; if (o.aw_cycles !== 1 || o.w_cycles !== 1) begin
            n_bad++; $display("FAIL wr_basic_valid_len got aw=%0d w=%0d want 1/1", o.aw_cycles, o.w_cycles); end
        n_cmp++; if (o.rsp_cycle !== 3 || o.idle_cycle !== 4) begin
            n_bad++; $display("FAIL wr_basic_latency got rsp@%0d idle@%0d want 3/4", o.rsp_cycle, o.idle_cycle); end
        n_cmp++; if (o.rsp_write !== 1'b1 || o.rsp_resp !== 2'b00 || o.rsp_rdata !== '0) begin
            n_bad++; $display("FAIL wr_basic_rsp got w=%b resp=%0d rd=%h want 1/0/0", o.rsp_write, o.rsp_resp, o.rsp_rdata); end
        n_cmp++; if (o.axi_bad || o.rsp_bad || o.bready_bad || o.cmd_ready_busy) begin
            n_bad++; $display("FAIL wr_basic_protocol got %b%b%b%b want 0000", o.axi_bad, o.rsp_bad, o.bready_bad, o.cmd_ready_busy); end
    endtask

    task automatic test_write_aw_delay();
        obs_t o;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = AW'($urandom_range(0, 7) * 4);
        d = $urandom;
        ref_mem[a] = merge(ref_read(a), d, 4'b0101);
        run_txn(1, a, d, 4'b0101, 3, 0, 0, 0, 2'b00, 0, o);
        n_cmp++; if (o.aw_cycles !== 4 || o.w_cycles !== 1) begin
            n_bad++; $display("FAIL wr_awdelay_valid_len got aw=%0d w=%0d want 4/1", o.aw_cycles, o.w_cycles); end
        n_cmp++; if (o.bready_bad) begin n_bad++; $display("FAIL wr_awdelay_bready_early got 1 want 0"); end
        n_cmp++; if (o.timeout || o.axi_bad || o.rsp_bad || o.rsp_write !== 1'b1 || o.rsp_resp !== 2'b00) begin
            n_bad++; $display("FAIL wr_awdelay_rsp got to=%b bad=%b%b w=%b resp=%0d want 0/00/1/0",
                o.timeout, o.axi_bad, o.rsp_bad, o.rsp_write, o.rsp_resp); end
        n_cmp++; if (o.axi_addr !== a || o.wdata !== d) begin
            n_bad++; $display("FAIL wr_awdelay_axi got %h/%h want %h/%h", o.axi_addr, o.wdata, a, d); end
    endtask

    task automatic test_read_slverr();
        obs_t o;
        ref_mem[12'h0FC] = 32'h12345678;
        sub_mem[12'h0FC] = 32'h12345678;
`ifdef ADC2AXI_ERRCNT_EN
        n_cmp++; if (err_count !== exp_err()) begin n_bad++; $display("FAIL rd_err_count_before got %0d want %0d", err_count, exp_err()); end
`endif
        run_txn(0, 12'h0FC, '0, '0, 0, 0, 2, 0, 2'b10, 0, o);
        err_n++;
        n_cmp++; if (o.rsp_rdata !== 32'h12345678 || o.rsp_resp !== 2'b10 || o.rsp_write !== 1'b0) begin
            n_bad++; $display("FAIL rd_slverr_rsp got rd=%h resp=%0d w=%b want 12345678/2/0", o.rsp_rdata, o.rsp_resp, o.rsp_write); end
        n_cmp++; if (o.ar_cycles !== 3 || o.axi_addr !== 12'h0FC) begin
            n_bad++; $display("FAIL rd_slverr_ar got cycles=%0d addr=%h want 3/0fc", o.ar_cycles, o.axi_addr); end
        n_cmp++; if (o.timeout || o.axi_bad || o.rsp_bad || o.bready_bad) begin
            n_bad++; $display("FAIL rd_slverr_protocol got %b%b%b%b want 0000", o.timeout, o.axi_bad, o.rsp_bad, o.bready_bad); end
`ifdef ADC2AXI_ERRCNT_EN
        n_cmp++; if (err_count !== exp_err()) begin n_bad++; $display("FAIL rd_err_count_after got %0d want %0d", err_count, exp_err()); end
`endif
    endtask

    task automatic test_rsp_backpressure();
        obs_t o;
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 7) * 4);
        run_txn(0, a, '0, '0, 0, 0, 0, 0, 2'b00, 5, o);
        n_cmp++; if (o.rsp_bad) begin n_bad++; $display("FAIL bp_rsp_stable got unstable want stable"); end
        n_cmp++; if (o.cmd_ready_busy) begin n_bad++; $display("FAIL bp_cmd_ready got 1 while busy want 0"); end
        n_cmp++; if (o.rsp_cycle !== 3 || o.idle_cycle !== 9) begin
            n_bad++; $display("FAIL bp_timing got rsp@%0d idle@%0d want 3/9", o.rsp_cycle, o.idle_cycle); end
        n_cmp++; if (o.rsp_rdata !== ref_read(a) || o.rsp_resp !== 2'b00 || o.timeout) begin
            n_bad++; $display("FAIL bp_data got %h/%0d want %h/0", o.rsp_rdata, o.rsp_resp, ref_read(a)); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        @(negedge ACLK);
        bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 12'h200; bus.cmd_wdata = 32'hFFFF_0000; bus.cmd_wstrb = 4'hF;
        @(negedge ACLK);
        bus.cmd_valid = 0; bus.AWREADY = 1; bus.WREADY = 1;
        @(negedge ACLK);
        bus.AWREADY = 0; bus.WREADY = 0;
        n_cmp++; if (bus.BREADY !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_wr_resp got BREADY=%b want 1", bus.BREADY); end
        ARESETn = 0;
        @(negedge ACLK);
        n_cmp++;
        if ({bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY, bus.rsp_valid, bus.cmd_ready} !== 7'b0) begin
            n_bad++; $display("FAIL rstmid_outputs got %b want 0000000",
                {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY, bus.rsp_valid, bus.cmd_ready});
        end
        ARESETn = 1;
        err_n = 0;
        @(negedge ACLK);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle got cmd_ready=%b want 1", bus.cmd_ready); end
        run_txn(0, 12'h010, '0, '0, 1, 0, 1, 1, 2'b00, 0, o);
        n_cmp++; if (o.timeout || o.rsp_rdata !== ref_read(12'h010) || o.rsp_write !== 1'b0 || o.axi_bad) begin
            n_bad++; $display("FAIL rstmid_read_after got rd=%h to=%b bad=%b want %h/0/0",
                o.rsp_rdata, o.timeout, o.axi_bad, ref_read(12'h010)); end
    endtask

`ifdef ADC2AXI_ERRCNT_EN
    task automatic test_errcnt_saturate();
        obs_t o;
        ARESETn = 0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1;
        err_n = 0;
        for (int k = 1; k <= 5; k++) begin
            run_txn(0, AW'($urandom_range(0, 7) * 4), '0, '0, 0, 0, 0, 0, 2'b11, 0, o);
            err_n++;
            n_cmp++; if (err_count !== exp_err() || o.rsp_resp !== 2'b11) begin
                n_bad++; $display("FAIL errcnt_sat_%0d got cnt=%0d resp=%0d want %0d/3", k, err_count, o.rsp_resp, exp_err()); end
        end
    endtask
`endif

    task automatic test_random();
        obs_t o;
        bit wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d, exp_rd;
        logic [SW-1:0] s;
        logic [1:0] r;
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 7) * 4);
            d = $urandom;
            s = SW'($urandom);
            r = 2'($urandom_range(0, 3));
            exp_rd = wr ? '0 : ref_read(a);
            if (wr) ref_mem[a] = merge(ref_read(a), d, s);
            run_txn(wr, a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), r, $urandom_range(0, 2), o);
            if (r[1]) err_n++;
            n_cmp++; if (o.rsp_write !== wr || o.rsp_rdata !== exp_rd || o.rsp_resp !== r) begin
                n_bad++; $display("FAIL rand_%0d_rsp got w=%b rd=%h resp=%0d want %b/%h/%0d",
                    t, o.rsp_write, o.rsp_rdata, o.rsp_resp, wr, exp_rd, r); end
            n_cmp++; if (o.timeout || o.axi_bad || o.rsp_bad || o.bready_bad || o.cmd_ready_busy || o.axi_addr !== a ||
                         (wr && (o.wdata !== d || o.wstrb !== s))) begin
                n_bad++; $display("FAIL rand_%0d_axi got to=%b bad=%b%b%b%b addr=%h want 0/0000/%h",
                    t, o.timeout, o.axi_bad, o.rsp_bad, o.bready_bad, o.cmd_ready_busy, o.axi_addr, a); end
`ifdef ADC2AXI_ERRCNT_EN
            n_cmp++; if (err_count !== exp_err()) begin
                n_bad++; $display("FAIL rand_%0d_err_count got %0d want %0d", t, err_count, exp_err()); end
`endif
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write_basic();
        test_write_aw_delay();
        test_read_slverr();
        test_rsp_backpressure();
        test_reset_mid();
`ifdef ADC2AXI_ERRCNT_EN
        test_errcnt_saturate();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
